// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: memop encoding, FSM states,
// CLINT window defaults and the access-size helper.
package lsu_stage_pkg;

  localparam logic [2:0] MOP_NONE = 3'd0;
  localparam logic [2:0] MOP_B    = 3'd1;
  localparam logic [2:0] MOP_H    = 3'd2;
  localparam logic [2:0] MOP_W    = 3'd3;
  localparam logic [2:0] MOP_D    = 3'd4;
  localparam logic [2:0] MOP_BU   = 3'd5;
  localparam logic [2:0] MOP_HU   = 3'd6;
  localparam logic [2:0] MOP_WU   = 3'd7;

  localparam logic [63:0] CLINT_BASE_DEF = 64'h0000_0000_0200_0000;
  localparam logic [63:0] CLINT_LAST_DEF = 64'h0000_0000_0200_BFFF;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;

  // log2 of access size in bytes; doublewords collapse to words on RV32
  function automatic logic [1:0] mop_lg2(input logic [2:0] mop, input int xlen);
    case (mop)
      MOP_H, MOP_HU: return 2'd1;
      MOP_W, MOP_WU: return 2'd2;
      MOP_D:         return (xlen == 64) ? 2'd3 : 2'd2;
      default:       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// EXU/WB handshakes, data bus and CLINT port bundle of the load/store stage.
interface lsu_stage_if #(parameter int XLEN = 64, parameter int SB_W = 200);
  logic              in_valid, in_ready;
  logic [XLEN-1:0]   in_addr, in_wdata;
  logic [2:0]        in_memop;
  logic              in_we;
  logic [SB_W-1:0]   in_sb;

  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_rdata, out_alures;
  logic [SB_W-1:0]   out_sb;
  logic              out_fault;

  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [XLEN-1:0]   mem_req_addr, mem_req_wdata;
  logic [XLEN/8-1:0] mem_req_wstrb;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_rdata;

  logic              clint_re, clint_we;
  logic [XLEN-1:0]   clint_addr, clint_wdata, clint_rdata;
  logic              clint_mtip_i, clint_mtip;

  modport master (
    input  in_valid, in_addr, in_wdata, in_memop, in_we, in_sb, out_ready,
           mem_req_ready, mem_resp_valid, mem_resp_rdata, clint_rdata, clint_mtip_i,
    output in_ready, out_valid, out_rdata, out_alures, out_sb, out_fault,
           mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
           clint_re, clint_we, clint_addr, clint_wdata, clint_mtip
  );

  modport slave (
    output in_valid, in_addr, in_wdata, in_memop, in_we, in_sb, out_ready,
           mem_req_ready, mem_resp_valid, mem_resp_rdata, clint_rdata, clint_mtip_i,
    input  in_ready, out_valid, out_rdata, out_alures, out_sb, out_fault,
           mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
           clint_re, clint_we, clint_addr, clint_wdata, clint_mtip
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane placement for stores and lane extraction with sign/zero
// extension for loads; purely combinational.
module lsu_align import lsu_stage_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic [2:0]                 memop_i,
  input  logic [$clog2(XLEN/8)-1:0]  off_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic [XLEN-1:0]            rdata_i,
  output logic [XLEN-1:0]            wdata_o,
  output logic [XLEN/8-1:0]          wstrb_o,
  output logic [XLEN-1:0]            ldata_o
);
  localparam int NB = XLEN/8;

  logic [1:0]      lg2;
  logic [NB-1:0]   mask;
  logic [XLEN-1:0] lane;

  assign lg2  = mop_lg2(memop_i, XLEN);
  assign lane = rdata_i >> {off_i, 3'b000};

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++)
      if (i < (1 << lg2)) mask[i] = 1'b1;
    wstrb_o = (memop_i == MOP_NONE) ? '0 : (mask << off_i);
    // replicating the low bytes puts them in every lane, including the addressed one
    case (lg2)
      2'd0:    wdata_o = {NB{wdata_i[7:0]}};
      2'd1:    wdata_o = {(NB/2){wdata_i[15:0]}};
      2'd2:    wdata_o = {(NB/4){wdata_i[31:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  always_comb begin
    case (memop_i)
      MOP_B:   ldata_o = XLEN'($signed(lane[7:0]));
      MOP_H:   ldata_o = XLEN'($signed(lane[15:0]));
      MOP_W:   ldata_o = XLEN'($signed(lane[31:0]));
      MOP_BU:  ldata_o = XLEN'(lane[7:0]);
      MOP_HU:  ldata_o = XLEN'(lane[15:0]);
      MOP_WU:  ldata_o = XLEN'(lane[31:0]);
      MOP_D:   ldata_o = lane;
      default: ldata_o = '0;
    endcase
  end
endmodule

// File: rtl/lsu_stage.sv
// Load/store stage between EXU and WB: one access in flight, misalignment trap,
// optional same-cycle CLINT window enabled by `define LSU_CLINT_EN.
module lsu_stage import lsu_stage_pkg::*; #(
  parameter int          XLEN       = 64,
  parameter int          SB_W       = 200,
  parameter logic [63:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [63:0] CLINT_LAST = CLINT_LAST_DEF
) (
  input logic         clk,
  input logic         rst,
  lsu_stage_if.master io
);
  localparam int NB   = XLEN/8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, raw_q, raw_d;
  logic [2:0]      memop_q, memop_d;
  logic [SB_W-1:0] sb_q, sb_d;
  logic            ld_q, ld_d, st_q, st_d, fault_q, fault_d;

  logic            in_ld, in_st, in_mis, in_clint, accept, go_bus;
  logic [1:0]      in_lg2;
  logic [OFFW-1:0] in_off, sz_mask;
  logic [XLEN-1:0] al_wdata, al_ldata;
  logic [NB-1:0]   al_wstrb;

  assign in_ld   = (io.in_memop != MOP_NONE) && !io.in_we;
  assign in_st   = io.in_we && (io.in_memop inside {MOP_B, MOP_H, MOP_W, MOP_D});
  assign in_lg2  = mop_lg2(io.in_memop, XLEN);
  assign in_off  = io.in_addr[OFFW-1:0];
  assign sz_mask = OFFW'((1 << in_lg2) - 1);
  assign in_mis  = (in_ld || in_st) && |(in_off & sz_mask);

`ifdef LSU_CLINT_EN
  logic [63:0] in_addr64;
  assign in_addr64 = 64'(io.in_addr);
  assign in_clint  = (in_ld || in_st) && !in_mis &&
                     (in_addr64 >= CLINT_BASE) && (in_addr64 <= CLINT_LAST);
`else
  assign in_clint  = 1'b0;
`endif

  assign accept = io.in_valid && io.in_ready;
  assign go_bus = (in_ld || in_st) && !in_mis && !in_clint;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      raw_q   <= '0;
      memop_q <= MOP_NONE;
      sb_q    <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      raw_q   <= raw_d;
      memop_q <= memop_d;
      sb_q    <= sb_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      fault_q <= fault_d;
    end
  end

  // an accept (from IDLE or back-to-back from DONE) overrides the hold/drain path
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (io.mem_req_ready)  state_d = S_WAIT;
      S_WAIT:  if (io.mem_resp_valid) state_d = S_DONE;
      S_DONE:  if (io.out_ready)      state_d = S_IDLE;
      default: ;
    endcase
    if (accept) state_d = go_bus ? S_REQ : S_DONE;
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raw_d   = raw_q;
    memop_d = memop_q;
    sb_d    = sb_q;
    ld_d    = ld_q;
    st_d    = st_q;
    fault_d = fault_q;
    if (accept) begin
      addr_d  = io.in_addr;
      wdata_d = io.in_wdata;
      memop_d = io.in_memop;
      sb_d    = io.in_sb;
      ld_d    = in_ld && !in_mis;
      st_d    = in_st && !in_mis;
      fault_d = in_mis;
      raw_d   = in_clint ? io.clint_rdata : '0;
    end else if (state_q == S_WAIT && io.mem_resp_valid) begin
      raw_d   = io.mem_resp_rdata;
    end
  end

  always_comb begin
    io.in_ready      = (state_q == S_IDLE) || (state_q == S_DONE && io.out_ready);
    io.out_valid     = (state_q == S_DONE);
    io.mem_req_valid = (state_q == S_REQ);
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .memop_i (memop_q),
    .off_i   (addr_q[OFFW-1:0]),
    .wdata_i (wdata_q),
    .rdata_i (raw_q),
    .wdata_o (al_wdata),
    .wstrb_o (al_wstrb),
    .ldata_o (al_ldata)
  );

  assign io.out_alures    = addr_q;
  assign io.out_sb        = sb_q;
  assign io.out_fault     = fault_q;
  assign io.out_rdata     = ld_q ? al_ldata : '0;
  assign io.mem_req_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign io.mem_req_we    = st_q;
  assign io.mem_req_wdata = al_wdata;
  assign io.mem_req_wstrb = st_q ? al_wstrb : '0;

`ifdef LSU_CLINT_EN
  logic clint_acc, mtip_q;
  // rst gating keeps the strobes quiet while the FSM is held in reset
  assign clint_acc      = accept && in_clint && rst;
  assign io.clint_re    = clint_acc && in_ld;
  assign io.clint_we    = clint_acc && in_st;
  assign io.clint_addr  = clint_acc ? io.in_addr : '0;
  assign io.clint_wdata = (clint_acc && in_st) ? io.in_wdata : '0;
  assign io.clint_mtip  = mtip_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mtip_q <= 1'b0;
    else      mtip_q <= io.clint_mtip_i;
  end
`else
  logic unused_clint;
  assign unused_clint   = ^{io.clint_mtip_i, CLINT_BASE, CLINT_LAST};
  assign io.clint_re    = 1'b0;
  assign io.clint_we    = 1'b0;
  assign io.clint_addr  = '0;
  assign io.clint_wdata = '0;
  assign io.clint_mtip  = 1'b0;
`endif
endmodule

// File: tb/tb_lsu_stage.sv
// Directed + randomized bench for lsu_stage against a byte-level reference model.
module tb_lsu_stage;
  localparam int XLEN = 64;
  localparam int SB_W = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lsu_stage_if #(.XLEN(XLEN), .SB_W(SB_W)) bus ();
  lsu_stage #(.XLEN(XLEN), .SB_W(SB_W)) dut (.clk(clk), .rst(rst), .io(bus));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic int msize(input logic [2:0] m);
    case (m)
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      3'd3, 3'd7: return 4;
      3'd4:       return 8;
      default:    return 0;
    endcase
  endfunction

  // pick size bytes starting at the byte offset, then extend per signedness
  function automatic logic [63:0] ref_load(input logic [2:0] m, input int off, input logic [63:0] w);
    int sz;
    logic [63:0] v;
    sz = msize(m);
    v = '0;
    for (int b = 0; b < sz; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
    if ((m == 3'd1 || m == 3'd2 || m == 3'd3) && v[8*sz-1])
      for (int b = sz; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  // Issue one op (from IDLE or back-to-back from DONE), service the bus, leave it in DONE.
  task automatic txn(input logic [2:0] m, input logic we, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] rw, input int dly);
    int sz, off;
    bit ld, st, mem, mis, clint, viabus;
    logic [SB_W-1:0] sb;
    logic [7:0]  ws;
    logic [63:0] bm, ed, rexp, abase;
    sz  = msize(m);
    off = int'(a[2:0]);
    ld  = (m != 3'd0) && !we;
    st  = we && (m >= 3'd1) && (m <= 3'd4);
    mem = ld || st;
    mis = mem ? ((off % sz) != 0) : 1'b0;
    clint = 1'b0;
`ifdef LSU_CLINT_EN
    clint = mem && !mis && (a >= 64'h0200_0000) && (a <= 64'h0200_BFFF);
`endif
    viabus = mem && !mis && !clint;
    abase  = {a[63:3], 3'b000};
    for (int i = 0; i < SB_W; i++) sb[i] = 1'($urandom);

    bus.in_valid = 1'b1; bus.in_addr = a; bus.in_wdata = wd; bus.in_memop = m;
    bus.in_we = we; bus.in_sb = sb; bus.out_ready = 1'b1;
    bus.clint_rdata = clint ? rw : 64'hDEAD_BEEF_0BAD_F00D;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = ~rw;
    #1;
    chk("in_ready_accept", 256'(bus.in_ready), 256'(1'b1));
    chk("clint_re_accept", 256'(bus.clint_re), 256'(clint && ld));
    chk("clint_we_accept", 256'(bus.clint_we), 256'(clint && st));
    if (clint) chk("clint_addr", 256'(bus.clint_addr), 256'(a));
    @(posedge clk);
    tick;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    #1;
    chk("clint_re_pulse", 256'(bus.clint_re), 256'(1'b0));
    if (viabus) begin
      chk("req_valid", 256'(bus.mem_req_valid), 256'(1'b1));
      chk("req_addr", 256'(bus.mem_req_addr), 256'(abase));
      chk("req_we", 256'(bus.mem_req_we), 256'(st));
      chk("out_valid_early", 256'(bus.out_valid), 256'(1'b0));
      if (st) begin
        ws = 8'((((1 << sz) - 1) << off));
        bm = '0; ed = '0;
        for (int i = 0; i < 8; i++)
          if (ws[i]) begin bm[8*i +: 8] = 8'hFF; ed[8*i +: 8] = wd[8*(i-off) +: 8]; end
        chk("req_wstrb", 256'(bus.mem_req_wstrb), 256'(ws));
        chk("req_wdata", 256'(bus.mem_req_wdata & bm), 256'(ed));
      end
      for (int d = 0; d < dly; d++) begin
        bus.mem_req_ready = 1'b0;
        if (d == 0) begin bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = ~rw; end
        tick;
        bus.mem_resp_valid = 1'b0;
        #1;
        chk("stall_valid", 256'(bus.mem_req_valid), 256'(1'b1));
        chk("stall_addr", 256'(bus.mem_req_addr), 256'(abase));
        chk("stall_in_ready", 256'(bus.in_ready), 256'(1'b0));
      end
      bus.mem_req_ready = 1'b1;
      tick;
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = rw;
      #1;
      chk("wait_no_out", 256'(bus.out_valid), 256'(1'b0));
      tick;
      bus.mem_resp_valid = 1'b0;
      #1;
    end else begin
      chk("no_bus_req", 256'(bus.mem_req_valid), 256'(1'b0));
    end
    rexp = (ld && !mis) ? ref_load(m, off, rw) : 64'd0;
    chk("out_valid", 256'(bus.out_valid), 256'(1'b1));
    chk("out_rdata", 256'(bus.out_rdata), 256'(rexp));
    chk("out_fault", 256'(bus.out_fault), 256'(mis));
    chk("out_alures", 256'(bus.out_alures), 256'(a));
    chk("out_sb", 256'(bus.out_sb), 256'(sb));
    tick; #1;
    chk("hold_valid", 256'(bus.out_valid), 256'(1'b1));
    chk("hold_rdata", 256'(bus.out_rdata), 256'(rexp));
  endtask

  task automatic drain;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    #1;
    chk("drain_valid", 256'(bus.out_valid), 256'(1'b0));
    chk("drain_in_ready", 256'(bus.in_ready), 256'(1'b1));
  endtask

  initial begin
    logic [63:0] r64;
    int reg_sel;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_memop = '0;
    bus.in_we = 1'b0; bus.in_sb = '0; bus.out_ready = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    bus.clint_rdata = '0; bus.clint_mtip_i = 1'b0;

    // reset state
    tick; tick; #1;
    chk("rst_out_valid", 256'(bus.out_valid), 256'(1'b0));
    chk("rst_req_valid", 256'(bus.mem_req_valid), 256'(1'b0));
    chk("rst_clint_re", 256'(bus.clint_re), 256'(1'b0));
    chk("rst_clint_we", 256'(bus.clint_we), 256'(1'b0));
    chk("rst_mtip", 256'(bus.clint_mtip), 256'(1'b0));
    chk("rst_fault", 256'(bus.out_fault), 256'(1'b0));
    chk("rst_rdata", 256'(bus.out_rdata), 256'(64'd0));
    chk("rst_alures", 256'(bus.out_alures), 256'(64'd0));
    chk("rst_sb", 256'(bus.out_sb), 256'(200'd0));
    rst = 1'b1;

    // LW sign-extending from upper word, zero-wait bus
    txn(3'd3, 1'b0, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0);
    chk("lw_const", 256'(bus.out_rdata), 256'(64'hFFFF_FFFF_8765_4321));
    // SB into lane 3
    txn(3'd1, 1'b1, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'd0, 0);
    chk("sb_wstrb_const", 256'(bus.mem_req_wstrb), 256'(8'h08));
    chk("sb_addr_const", 256'(bus.mem_req_addr), 256'(64'h8000_0000));
    // LD with 5-cycle request stall
    txn(3'd4, 1'b0, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 5);
    // LD at the top doubleword of the CLINT window
    txn(3'd4, 1'b0, 64'h0200_BFF8, 64'd0, 64'hCAFE_0000_1234_5678, 0);
    // misaligned LH
    txn(3'd2, 1'b0, 64'h8000_0001, 64'd0, 64'h1111_2222_3333_4444, 0);
    // non-memory op
    txn(3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 0);
    drain;

    // reset asserted while waiting for a response; the late response must be dropped
    bus.in_valid = 1'b1; bus.in_addr = 64'h8000_0020; bus.in_memop = 3'd3; bus.in_we = 1'b0;
    @(posedge clk);
    tick;
    bus.in_valid = 1'b0; bus.mem_req_ready = 1'b1;
    tick;
    bus.mem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("wrst_out_valid", 256'(bus.out_valid), 256'(1'b0));
    chk("wrst_req_valid", 256'(bus.mem_req_valid), 256'(1'b0));
    chk("wrst_alures", 256'(bus.out_alures), 256'(64'd0));
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'hFFFF_0000_FFFF_0000;
    tick;
    rst = 1'b1;
    tick;
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("wrst_resp_dropped", 256'(bus.out_valid), 256'(1'b0));
    chk("wrst_idle", 256'(bus.in_ready), 256'(1'b1));

    // timer interrupt pass-through
    bus.clint_mtip_i = 1'b1;
    #1;
    chk("mtip_not_yet", 256'(bus.clint_mtip), 256'(1'b0));
    tick; #1;
`ifdef LSU_CLINT_EN
    chk("mtip_delayed", 256'(bus.clint_mtip), 256'(1'b1));
`else
    chk("mtip_tied", 256'(bus.clint_mtip), 256'(1'b0));
`endif
    bus.clint_mtip_i = 1'b0;
    tick; #1;
    chk("mtip_clear", 256'(bus.clint_mtip), 256'(1'b0));

    // randomized mix, including the CLINT upper boundary
    for (int n = 0; n < 60; n++) begin
      reg_sel = $urandom_range(2);
      r64 = (reg_sel == 0) ? 64'h8000_0000 + 64'($urandom_range(255)) :
            (reg_sel == 1) ? 64'h0200_0000 + 64'($urandom_range(255)) :
                             64'h0200_BFF0 + 64'($urandom_range(31));
      txn(3'($urandom), ($urandom_range(2) == 0), r64,
          {$urandom(), $urandom()}, {$urandom(), $urandom()}, $urandom_range(2));
      if ($urandom_range(1) == 0) drain;
    end
    drain;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
